// File: rtl/controle_pkg.sv
// State codes for the memory-game control FSM; the display decoder uses the
// same constants to show db_estado.
package controle_pkg;
  localparam logic [3:0] ST_INICIAL     = 4'h0;
  localparam logic [3:0] ST_PREPARACAO  = 4'h1;
  localparam logic [3:0] ST_ESPERA      = 4'h2;
  localparam logic [3:0] ST_REGISTRA    = 4'h3;
  localparam logic [3:0] ST_COMPARACAO  = 4'h4;
  localparam logic [3:0] ST_PROXIMO     = 4'h5;
  localparam logic [3:0] ST_FIM_ACERTO  = 4'hA;
  localparam logic [3:0] ST_FIM_ERRO    = 4'hE;
  localparam logic [3:0] ST_FIM_TIMEOUT = 4'hD;

  typedef struct packed {
    logic zerac;
    logic contac;
    logic zerar;
    logic registrar;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } ctrl_out_t;
endpackage

// File: rtl/unidade_controle_if.sv
// Status/strobe bundle between the control FSM and the fluxo_dados datapath.
interface unidade_controle_if;
  logic       iniciar;
  logic       fimC;
  logic       jogada_feita;
  logic       igual;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  // master: the FSM side; slave: the datapath / environment side
  modport master (
    input  iniciar, fimC, jogada_feita, igual,
    output zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );
  modport slave (
    output iniciar, fimC, jogada_feita, igual,
    input  zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );
endinterface

// File: rtl/contador_timeout.sv
// Play-window counter: sync clear, enable, saturates at TIMEOUT_CYCLES-1 and
// flags that terminal count.
module contador_timeout #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TW             = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (en && cnt_q != LAST) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign tc = (cnt_q == LAST);
endmodule

// File: rtl/unidade_controle.sv
// Moore FSM sequencing one 16-position round of the memory game: prepare,
// wait for a play, register, compare, advance; ends in hit, miss or timeout.
module unidade_controle
  import controle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TW             = 13
) (
  input  logic               clock,
  input  logic               reset,
  unidade_controle_if.master ctl
);
  logic [3:0] estado_q, estado_d;
  logic       em_espera, tmo_tc;
  ctrl_out_t  out;

  assign em_espera = (estado_q == ST_ESPERA);

  // Cleared outside espera so every play gets a fresh window
  contador_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TW(TW)) u_tmo (
    .clock (clock),
    .reset (reset),
    .clr   (!em_espera),
    .en    (em_espera),
    .tc    (tmo_tc)
  );

  always_ff @(posedge clock or negedge reset)
    if (!reset) estado_q <= ST_INICIAL;
    else        estado_q <= estado_d;

  // Outputs depend on estado_q only; inputs steer estado_d alone
  always_comb begin
    estado_d = ST_INICIAL;
    out      = '0;
    case (estado_q)
      ST_INICIAL:    estado_d = ctl.iniciar ? ST_PREPARACAO : ST_INICIAL;
      ST_PREPARACAO: begin
        out.zerac = 1'b1;
        out.zerar = 1'b1;
        estado_d  = ST_ESPERA;
      end
      ST_ESPERA:
        if (ctl.jogada_feita) estado_d = ST_REGISTRA;
        else if (tmo_tc)      estado_d = ST_FIM_TIMEOUT;
        else                  estado_d = ST_ESPERA;
      ST_REGISTRA: begin
        out.registrar = 1'b1;
        estado_d      = ST_COMPARACAO;
      end
      ST_COMPARACAO:
        if (!ctl.igual)    estado_d = ST_FIM_ERRO;
        else if (ctl.fimC) estado_d = ST_FIM_ACERTO;
        else               estado_d = ST_PROXIMO;
      ST_PROXIMO: begin
        out.contac = 1'b1;
        estado_d   = ST_ESPERA;
      end
      ST_FIM_ACERTO: begin
        out.pronto  = 1'b1;
        out.acertou = 1'b1;
        estado_d    = ctl.iniciar ? ST_PREPARACAO : ST_FIM_ACERTO;
      end
      ST_FIM_ERRO: begin
        out.pronto = 1'b1;
        out.errou  = 1'b1;
        estado_d   = ctl.iniciar ? ST_PREPARACAO : ST_FIM_ERRO;
      end
      ST_FIM_TIMEOUT: begin
        out.pronto  = 1'b1;
        out.errou   = 1'b1;
        out.timeout = 1'b1;
        estado_d    = ctl.iniciar ? ST_PREPARACAO : ST_FIM_TIMEOUT;
      end
      default:       estado_d = ST_INICIAL;
    endcase
  end

  assign ctl.zeraC     = out.zerac;
  assign ctl.contaC    = out.contac;
  assign ctl.zeraR     = out.zerar;
  assign ctl.registraR = out.registrar;
  assign ctl.pronto    = out.pronto;
  assign ctl.acertou   = out.acertou;
  assign ctl.errou     = out.errou;
  assign ctl.timeout   = out.timeout;
  assign ctl.db_estado = estado_q;
endmodule

// File: tb/tb_unidade_controle.sv
// Round-level bench: each round is planned as a timeline of edges from the
// play schedule, then driven open-loop and compared edge by edge.
module tb_unidade_controle;
  localparam int T    = 8;
  localparam int MAXE = 256;
  localparam int HOLD = 3;
  localparam int OUT_A = 0, OUT_E = 1, OUT_D = 2;

  logic clock = 1'b0;
  logic reset;
  unidade_controle_if ctl();

  unidade_controle #(.TIMEOUT_CYCLES(T), .TW(4)) dut (
    .clock (clock),
    .reset (reset),
    .ctl   (ctl)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-edge drive values and expected strobes (index = edge after iniciar)
  bit jog[MAXE], igl[MAXE], fim[MAXE], ini[MAXE];
  bit e_zera[MAXE], e_conta[MAXE], e_reg[MAXE];
  int fin_edge, outcome;

  task automatic plan(input int mode);
    int e, d, m, spur;
    for (int i = 0; i < MAXE; i++) begin
      jog[i] = 0; igl[i] = 0; fim[i] = 0; ini[i] = 0;
      e_zera[i] = 0; e_conta[i] = 0; e_reg[i] = 0;
    end
    e_zera[0] = 1;
    e = 1;                       // espera entered at edge 1
    fin_edge = 0;
    for (int k = 0; k < 16; k++) begin
      case (mode)
        1:       begin d = 1; m = (k != 3); end
        2:       begin d = T + 1; m = 1; end
        3:       begin d = (k < 2) ? T : 1; m = 1; end
        4:       begin
          d = ($urandom_range(0, 19) == 0) ? T + $urandom_range(1, 3) : $urandom_range(1, T);
          m = ($urandom_range(0, 24) != 0);
        end
        default: begin d = 1; m = 1; end
      endcase
      if (d > T) begin
        fin_edge = e + T; outcome = OUT_D;
        break;
      end
      jog[e + d]   = 1;
      e_reg[e + d] = 1;
      for (int i = e + 1; i <= e + d + 2; i++) begin
        igl[i] = m[0];
        fim[i] = (k == 15);
      end
      spur = (mode == 4) ? $urandom_range(0, 2) : 0;
      if (spur != 0) jog[e + d + spur] = 1;     // lands in registra/comparacao
      if (!m)      begin fin_edge = e + d + 2; outcome = OUT_E; break; end
      if (k == 15) begin fin_edge = e + d + 2; outcome = OUT_A; break; end
      e_conta[e + d + 2] = 1;
      e = e + d + 3;
    end
    if (mode == 4) begin
      ini[$urandom_range(2, fin_edge - 1)] = 1;  // mid-round restart request
      jog[fin_edge + 1] = 1;
    end
  endtask

  function automatic logic [7:0] outs_vec();
    return {ctl.zeraC, ctl.zeraR, ctl.contaC, ctl.registraR,
            ctl.pronto, ctl.acertou, ctl.errou, ctl.timeout};
  endfunction

  function automatic logic [7:0] exp_vec(input int e);
    bit done;
    done = (e >= fin_edge);
    return {e_zera[e], e_zera[e], e_conta[e], e_reg[e], done,
            done && outcome == OUT_A, done && outcome != OUT_A, done && outcome == OUT_D};
  endfunction

  task automatic run_round(input int mode, input int reset_edge);
    logic [3:0] code;
    plan(mode);
    @(negedge clock);
    ctl.iniciar = 1; ctl.jogada_feita = 0;
    @(posedge clock); #1;
    chk($sformatf("m%0d outs@0", mode), outs_vec(), exp_vec(0));
    for (int e = 1; e <= fin_edge + HOLD; e++) begin
      @(negedge clock);
      ctl.iniciar = ini[e]; ctl.jogada_feita = jog[e];
      ctl.igual = igl[e];   ctl.fimC = fim[e];
      @(posedge clock); #1;
      chk($sformatf("m%0d outs@%0d", mode, e), outs_vec(), exp_vec(e));
      if (e == 1) chk($sformatf("m%0d espera@1", mode), ctl.db_estado, 4'h2);
      if (e == reset_edge) begin
        #2 reset = 0;
        #1;
        chk("async reset outs", outs_vec(), 8'h00);
        chk("async reset estado", ctl.db_estado, 4'h0);
        ctl.jogada_feita = 0; ctl.iniciar = 0;
        repeat (2) @(negedge clock);
        reset = 1;
        return;
      end
    end
    code = (outcome == OUT_A) ? 4'hA : (outcome == OUT_E) ? 4'hE : 4'hD;
    chk($sformatf("m%0d final estado", mode), ctl.db_estado, code);
  endtask

  initial begin
    reset = 0;
    ctl.iniciar = 0; ctl.jogada_feita = 0; ctl.igual = 0; ctl.fimC = 0;
    #1;
    chk("reset outs", outs_vec(), 8'h00);
    chk("reset estado", ctl.db_estado, 4'h0);
    @(negedge clock); reset = 1;
    @(negedge clock); ctl.jogada_feita = 1;     // dropped in inicial
    @(posedge clock); #1;
    chk("idle estado", ctl.db_estado, 4'h0);
    ctl.jogada_feita = 0;
    run_round(0, 0);   // full hit round, pronto after edge 64
    run_round(1, 0);   // miss on play 3
    run_round(0, 0);   // restart from fim_erro
    run_round(2, 0);   // immediate timeout
    run_round(3, 0);   // plays on last window cycle
    run_round(0, 29);  // reset mid-espera at position 7
    run_round(0, 0);
    for (int r = 0; r < 25; r++) run_round(4, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
